pll_lock_supervisor: RTL

- Sequences the Tang9K rPLL (27 MHz in, 72 MHz out) at power-up and after lock loss.
- Pulses the PLL RESET input and qualifies the asynchronous LOCK output with a stability window.
- Releases the system reset only once lock is stable; retries a bounded number of times, then latches a fault.
- Runs on the free-running 27 MHz crystal clock, never on the PLL output. Consumers in the 72 MHz domain re-synchronise sys_rst_n_o locally.

---
 rtl/pll_sup_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/pll_lock_supervisor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: FSM state encoding and counter widths.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   localparam int LOSS_CNT_W = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; 2-cycle latency, no backpressure.
// Resets to 0 asynchronously so downstream logic sees a deasserted input out of reset.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] meta_d;
   logic [W-1:0] sync_q;
   logic [W-1:0] sync_d;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences rPLL reset, qualifies LOCK over a stability window, releases system reset, retries then faults.
// Runs on the crystal clock; lock seen 2 cycles late through the synchroniser; all outputs registered.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 27,
   parameter int LOCK_TIMEOUT   = 27000,
   parameter int STABLE_CYCLES  = 2700,
   parameter int MAX_RETRIES    = 3
) (
   input  logic                               clkin,
   input  logic                               rst_n,
   input  logic                               pll_lock_i,
   input  logic                               restart_i,
   output logic                               pll_reset_o,
   output logic                               sys_rst_n_o,
   output logic                               ready_o,
   output logic                               fault_o,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o,
   output logic [LOSS_CNT_W-1:0]              loss_cnt_o,
   output logic [2:0]                         state_o
);

   localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int RETRY_W = $clog2(MAX_RETRIES+1);

   localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

   logic lock_s;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [RETRY_W-1:0]    retry_q, retry_d;
   logic [LOSS_CNT_W-1:0] loss_q, loss_d;
   logic                  pll_reset_q, pll_reset_d;
   logic                  sys_rst_n_q, sys_rst_n_d;
   logic                  ready_q, ready_d;
   logic                  fault_q, fault_d;
   logic                  attempt_fail;

   sync_2ff #(.W(1)) u_lock_sync (
      .clk   (clkin),
      .rst_n (rst_n),
      .d_i   (pll_lock_i),
      .q_o   (lock_s)
   );

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PLL_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         pll_reset_q <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         pll_reset_q <= pll_reset_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      retry_d      = retry_q;
      loss_d       = loss_q;
      attempt_fail = 1'b0;
      if (restart_i) begin
         state_d = PLL_RST;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            PLL_RST: begin
               if (cnt_q == RST_LAST) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == LOCK_LAST) begin
                  attempt_fail = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            STABLE: begin
               if (!lock_s) begin
                  attempt_fail = 1'b1;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = RUN;
                  cnt_d   = '0;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state_d = PLL_RST;
                  cnt_d   = '0;
                  if (loss_q != '1) begin
                     loss_d = loss_q + LOSS_CNT_W'(1);
                  end
               end
            end
            FAULT: begin
               state_d = FAULT;
            end
            default: begin
               state_d = PLL_RST;
               cnt_d   = '0;
            end
         endcase
         // A timeout and a lock drop during qualification both count as one failed attempt.
         if (attempt_fail) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
               state_d = FAULT;
            end else begin
               state_d = PLL_RST;
               retry_d = retry_q + RETRY_W'(1);
            end
         end
      end
   end

   // Outputs are decoded from the next state so they switch on the same edge as the state.
   always_comb begin
      pll_reset_d = (state_d == PLL_RST) || (state_d == FAULT);
      sys_rst_n_d = (state_d == RUN);
      ready_d     = (state_d == RUN);
      fault_d     = (state_d == FAULT);
   end

   assign pll_reset_o = pll_reset_q;
   assign sys_rst_n_o = sys_rst_n_q;
   assign ready_o     = ready_q;
   assign fault_o     = fault_q;
   assign retry_cnt_o = retry_q;
   assign loss_cnt_o  = loss_q;
   assign state_o     = state_q;

endmodule
